// File: rtl/conv_job_sched.sv
// Job scheduler for the convolution engine: queues descriptors, launches one
// job at a time, and recovers the engine on abort or timeout.
module conv_job_sched #(
    parameter int DEPTH = 4,
    parameter int TMO_W = 16
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       desc_valid,
    output logic                       desc_ready,
    input  logic [35:0]                desc_data,
    output logic [2:0]                 cfg_kern_cols,
    output logic [7:0]                 cfg_cols,
    output logic [2:0]                 cfg_kerns,
    output logic [5:0]                 cfg_stride,
    output logic                       cfg_kern_addr_mode,
    output logic [5:0]                 cfg_result_cols,
    output logic [3:0]                 cfg_shift,
    output logic                       cfg_en_max_pool,
    output logic [2:0]                 cfg_mask,
    output logic                       conv_start,
    input  logic                       conv_done,
    output logic                       conv_soft_reset,
    input  logic                       abort,
    input  logic [TMO_W-1:0]           timeout_cycles,
    input  logic                       err_clr,
    output logic                       busy,
    output logic                       irq,
    output logic                       err_timeout,
    output logic [7:0]                 job_cnt,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [2:0]                 dbg_state
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_RUN     = 3'd3,
        S_DONE    = 3'd4,
        S_RECOVER = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [35:0]       mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic [35:0]       cfg_q, cfg_d;
    logic [TMO_W-1:0]  timer_q, timer_d;
    logic              done_q;
    logic              rec_cnt_q, rec_cnt_d;
    logic              err_q, err_d;
    logic [7:0]        job_cnt_q, job_cnt_d;

    logic              full, empty, push, pop, rise, tmo_hit, err_set;

    // Handshake: a descriptor transfers on a rising clock edge where
    // desc_valid and desc_ready are both high; desc_ready never depends on
    // desc_valid, and the producer holds desc_data stable while desc_valid
    // is high and desc_ready is low.
    assign full       = (level_q == (AW+1)'(DEPTH));
    assign empty      = (level_q == '0);
    assign desc_ready = ~wb_rst_i & ~full & ~abort;
    assign push       = desc_valid & desc_ready;
    assign pop        = (state_q == S_IDLE) & ~empty & ~abort;
    assign rise       = conv_done & ~done_q;
    assign tmo_hit    = (timeout_cycles != '0) &&
                        (timer_q == timeout_cycles - TMO_W'(1));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem_q[wr_ptr_q] <= desc_data;
    end

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        timer_d   = timer_q;
        rec_cnt_d = rec_cnt_q;
        job_cnt_d = job_cnt_q;
        err_set   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_LOAD;
                    cfg_d   = mem_q[rd_ptr_q];
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d   = S_RECOVER;
                    rec_cnt_d = 1'b0;
                end else begin
                    state_d = S_START;
                end
            end
            S_START: begin
                timer_d = '0;
                if (abort) begin
                    state_d   = S_RECOVER;
                    rec_cnt_d = 1'b0;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                timer_d = timer_q + TMO_W'(1);
                // A completion in the same cycle as a timeout counts as success.
                if (rise) begin
                    state_d = S_DONE;
                end else if (abort) begin
                    state_d   = S_RECOVER;
                    rec_cnt_d = 1'b0;
                end else if (tmo_hit) begin
                    state_d   = S_RECOVER;
                    rec_cnt_d = 1'b0;
                    err_set   = 1'b1;
                end
            end
            S_DONE: begin
                if (job_cnt_q != 8'hFF) job_cnt_d = job_cnt_q + 8'd1;
                state_d = S_IDLE;
            end
            S_RECOVER: begin
                if (rec_cnt_q) state_d = S_IDLE;
                else           rec_cnt_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            cfg_q     <= '0;
            timer_q   <= '0;
            done_q    <= 1'b0;
            rec_cnt_q <= 1'b0;
            err_q     <= 1'b0;
            job_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            cfg_q     <= cfg_d;
            timer_q   <= timer_d;
            done_q    <= conv_done;
            rec_cnt_q <= rec_cnt_d;
            err_q     <= err_d;
            job_cnt_q <= job_cnt_d;
        end
    end

    assign cfg_kern_cols      = cfg_q[2:0];
    assign cfg_cols           = cfg_q[10:3];
    assign cfg_kerns          = cfg_q[13:11];
    assign cfg_stride         = cfg_q[19:14];
    assign cfg_kern_addr_mode = cfg_q[20];
    assign cfg_result_cols    = cfg_q[26:21];
    assign cfg_shift          = cfg_q[30:27];
    assign cfg_en_max_pool    = cfg_q[31];
    assign cfg_mask           = cfg_q[34:32];

    assign conv_start      = (state_q == S_START);
    assign conv_soft_reset = (state_q == S_RECOVER);
    assign irq             = (state_q == S_DONE) & cfg_q[35];
    assign busy            = (state_q != S_IDLE) | ~empty;
    assign err_timeout     = err_q;
    assign job_cnt         = job_cnt_q;
    assign fifo_level      = level_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_conv_job_sched.sv
// Directed bench for conv_job_sched: latency, fill, timeout, abort and reset.
module tb_conv_job_sched;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_START = 3'd2,
                           ST_RUN = 3'd3, ST_DONE = 3'd4, ST_RECOVER = 3'd5;

    logic        wb_clk_i, wb_rst_i, desc_valid, desc_ready;
    logic [35:0] desc_data;
    logic [2:0]  cfg_kern_cols, cfg_kerns, cfg_mask;
    logic [7:0]  cfg_cols;
    logic [5:0]  cfg_stride, cfg_result_cols;
    logic        cfg_kern_addr_mode, cfg_en_max_pool;
    logic [3:0]  cfg_shift;
    logic        conv_start, conv_done, conv_soft_reset, abort, err_clr;
    logic [15:0] timeout_cycles;
    logic        busy, irq, err_timeout;
    logic [7:0]  job_cnt;
    logic [2:0]  fifo_level, dbg_state;

    int n_assert = 0;
    int n_fail   = 0;

    conv_job_sched #(.DEPTH(4), .TMO_W(16)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_data(desc_data),
        .cfg_kern_cols(cfg_kern_cols), .cfg_cols(cfg_cols), .cfg_kerns(cfg_kerns),
        .cfg_stride(cfg_stride), .cfg_kern_addr_mode(cfg_kern_addr_mode),
        .cfg_result_cols(cfg_result_cols), .cfg_shift(cfg_shift),
        .cfg_en_max_pool(cfg_en_max_pool), .cfg_mask(cfg_mask),
        .conv_start(conv_start), .conv_done(conv_done),
        .conv_soft_reset(conv_soft_reset), .abort(abort),
        .timeout_cycles(timeout_cycles), .err_clr(err_clr),
        .busy(busy), .irq(irq), .err_timeout(err_timeout),
        .job_cnt(job_cnt), .fifo_level(fifo_level), .dbg_state(dbg_state)
    );

    // clock / reset
    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (conv_start !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk(tag, conv_start, 1'b1);
    endtask

    function automatic logic [35:0] mk(input logic [2:0] kc, input logic [7:0] cols,
                                       input logic [2:0] kerns, input logic [5:0] stride,
                                       input logic kam, input logic [5:0] rc,
                                       input logic [3:0] sh, input logic mp,
                                       input logic [2:0] mask, input logic ie);
        return {ie, mask, mp, sh, rc, kam, stride, kerns, cols, kc};
    endfunction

    task automatic push_one(input logic [35:0] d);
        desc_valid = 1'b1;
        desc_data  = d;
        #1;
        chk("push_ready", desc_ready, 1'b1);
        step();
        desc_valid = 1'b0;
    endtask

    logic [7:0] fill_cols [5];
    logic       fill_ie   [5];

    initial begin
        wb_rst_i = 1'b1; desc_valid = 1'b0; desc_data = '0; conv_done = 1'b0;
        abort = 1'b0; err_clr = 1'b0; timeout_cycles = '0;
        step();
        step();
        chk("rst_ready", desc_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_start", conv_start, 1'b0);
        chk("rst_level", fifo_level, 3'd0);
        chk("rst_jobcnt", job_cnt, 8'd0);
        chk("rst_state", dbg_state, ST_IDLE);
        wb_rst_i = 1'b0;
        step();

        // single job: accept in t, cfg at t+2, start at t+3, done 20 later
        desc_valid = 1'b1;
        desc_data  = mk(3'd3, 8'd8, 3'd2, 6'd1, 1'b1, 6'd6, 4'd5, 1'b1, 3'b101, 1'b1);
        #1;
        chk("t0_ready", desc_ready, 1'b1);
        step();
        desc_valid = 1'b0;
        chk("t1_level", fifo_level, 3'd1);
        chk("t1_cfg_cols", cfg_cols, 8'd0);
        chk("t1_start", conv_start, 1'b0);
        step();
        chk("t2_state", dbg_state, ST_LOAD);
        chk("t2_cols", cfg_cols, 8'd8);
        chk("t2_kcols", cfg_kern_cols, 3'd3);
        chk("t2_kerns", cfg_kerns, 3'd2);
        chk("t2_stride", cfg_stride, 6'd1);
        chk("t2_kam", cfg_kern_addr_mode, 1'b1);
        chk("t2_rcols", cfg_result_cols, 6'd6);
        chk("t2_shift", cfg_shift, 4'd5);
        chk("t2_pool", cfg_en_max_pool, 1'b1);
        chk("t2_mask", cfg_mask, 3'b101);
        chk("t2_start", conv_start, 1'b0);
        chk("t2_level", fifo_level, 3'd0);
        step();
        chk("t3_start", conv_start, 1'b1);
        step();
        chk("t4_start", conv_start, 1'b0);
        chk("t4_state", dbg_state, ST_RUN);
        repeat (18) step();
        chk("t22_state", dbg_state, ST_RUN);
        step();
        conv_done = 1'b1;
        step();
        chk("t24_irq", irq, 1'b1);
        chk("t24_state", dbg_state, ST_DONE);
        conv_done = 1'b0;
        step();
        chk("t25_irq", irq, 1'b0);
        chk("t25_jobcnt", job_cnt, 8'd1);
        chk("t25_busy", busy, 1'b0);

        // fill: 5 back-to-back pushes, first is popped at once, 4 queue up
        for (int k = 0; k < 5; k++) begin
            fill_cols[k] = 8'(20 + 7 * k);
            fill_ie[k]   = k[0];
        end
        for (int k = 0; k < 5; k++) begin
            desc_valid = 1'b1;
            desc_data  = mk(3'd1, fill_cols[k], 3'd0, 6'd2, 1'b0, 6'd3, 4'd0, 1'b0, 3'd0, fill_ie[k]);
            #1;
            chk("fill_ready", desc_ready, 1'b1);
            step();
        end
        desc_data = mk(3'd7, 8'hFF, 3'd7, 6'd63, 1'b1, 6'd63, 4'd15, 1'b1, 3'd7, 1'b1);
        #1;
        chk("full_ready", desc_ready, 1'b0);
        chk("full_level", fifo_level, 3'd4);
        desc_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k != 0) begin
                wait_start("fill_start");
                step();
            end
            chk("fill_cols", cfg_cols, fill_cols[k]);
            chk("fill_run", dbg_state, ST_RUN);
            conv_done = 1'b1;
            step();
            chk("fill_done", dbg_state, ST_DONE);
            chk("fill_irq", irq, fill_ie[k]);
            conv_done = 1'b0;
            step();
            chk("fill_idle", dbg_state, ST_IDLE);
            chk("fill_jobcnt", job_cnt, 8'(2 + k));
            step();
            if (k == 0) begin
                chk("b2b_load", dbg_state, ST_LOAD);
                chk("pop_level", fifo_level, 3'd3);
            end
        end
        chk("fill_end_busy", busy, 1'b0);
        chk("fill_end_level", fifo_level, 3'd0);

        // timeout after 10 RUN cycles
        timeout_cycles = 16'd10;
        push_one(mk(3'd2, 8'd50, 3'd1, 6'd1, 1'b0, 6'd4, 4'd1, 1'b0, 3'd1, 1'b1));
        wait_start("tmo_start");
        repeat (10) step();
        chk("tmo_run10", dbg_state, ST_RUN);
        chk("tmo_err_pre", err_timeout, 1'b0);
        step();
        chk("tmo_recover", dbg_state, ST_RECOVER);
        chk("tmo_srst1", conv_soft_reset, 1'b1);
        chk("tmo_err", err_timeout, 1'b1);
        chk("tmo_irq", irq, 1'b0);
        step();
        chk("tmo_srst2", conv_soft_reset, 1'b1);
        step();
        chk("tmo_srst_off", conv_soft_reset, 1'b0);
        chk("tmo_idle", dbg_state, ST_IDLE);
        chk("tmo_jobcnt", job_cnt, 8'd6);
        chk("tmo_err_sticky", err_timeout, 1'b1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("tmo_err_clr", err_timeout, 1'b0);

        // done rises on the 10th RUN cycle together with timeout
        push_one(mk(3'd2, 8'd60, 3'd1, 6'd1, 1'b0, 6'd4, 4'd1, 1'b0, 3'd1, 1'b1));
        wait_start("race_start");
        repeat (10) step();
        conv_done = 1'b1;
        chk("race_run10", dbg_state, ST_RUN);
        step();
        chk("race_done", dbg_state, ST_DONE);
        chk("race_err", err_timeout, 1'b0);
        chk("race_irq", irq, 1'b1);
        conv_done = 1'b0;
        step();
        chk("race_jobcnt", job_cnt, 8'd7);

        // abort in RUN with 2 queued
        timeout_cycles = 16'd0;
        for (int k = 0; k < 3; k++) begin
            desc_valid = 1'b1;
            desc_data  = mk(3'd1, 8'(90 + k), 3'd1, 6'd1, 1'b0, 6'd1, 4'd0, 1'b0, 3'd0, 1'b1);
            step();
        end
        desc_valid = 1'b0;
        wait_start("abt_start");
        chk("abt_level_pre", fifo_level, 3'd2);
        step();
        chk("abt_run", dbg_state, ST_RUN);
        abort = 1'b1;
        #1;
        chk("abt_ready", desc_ready, 1'b0);
        step();
        abort = 1'b0;
        chk("abt_recover", dbg_state, ST_RECOVER);
        chk("abt_level", fifo_level, 3'd0);
        chk("abt_srst1", conv_soft_reset, 1'b1);
        chk("abt_irq", irq, 1'b0);
        step();
        chk("abt_srst2", conv_soft_reset, 1'b1);
        step();
        chk("abt_idle", dbg_state, ST_IDLE);
        chk("abt_srst_off", conv_soft_reset, 1'b0);
        chk("abt_busy", busy, 1'b0);
        chk("abt_jobcnt", job_cnt, 8'd7);

        // asynchronous reset mid-RUN, then a clean job
        push_one(mk(3'd4, 8'd33, 3'd3, 6'd3, 1'b1, 6'd9, 4'd2, 1'b1, 3'd6, 1'b1));
        wait_start("ar_start");
        step();
        chk("ar_run", dbg_state, ST_RUN);
        #2;
        wb_rst_i = 1'b1;
        #1;
        chk("ar_state", dbg_state, ST_IDLE);
        chk("ar_jobcnt", job_cnt, 8'd0);
        chk("ar_cols", cfg_cols, 8'd0);
        chk("ar_mask", cfg_mask, 3'd0);
        chk("ar_busy", busy, 1'b0);
        chk("ar_ready", desc_ready, 1'b0);
        chk("ar_srst", conv_soft_reset, 1'b0);
        chk("ar_irq", irq, 1'b0);
        step();
        chk("ar_srst_hold", conv_soft_reset, 1'b0);
        wb_rst_i = 1'b0;
        step();
        push_one(mk(3'd5, 8'd77, 3'd1, 6'd2, 1'b0, 6'd5, 4'd3, 1'b0, 3'd2, 1'b1));
        wait_start("post_start");
        chk("post_cols", cfg_cols, 8'd77);
        chk("post_kcols", cfg_kern_cols, 3'd5);
        step();
        conv_done = 1'b1;
        step();
        chk("post_irq", irq, 1'b1);
        conv_done = 1'b0;
        step();
        chk("post_jobcnt", job_cnt, 8'd1);
        chk("post_busy", busy, 1'b0);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
